// File: rtl/cma_host_ctrl.sv
// rtl/cma_host_ctrl.sv - host-side sequencer: delay, load image, run until DONE, read back result window
module cma_host_ctrl #(
  parameter int    DATA_W      = 24,
  parameter int    EXA_W       = 15,
  parameter int    ROMULTIC_W  = 8,
  parameter int    LOAD_COUNT  = 64,
  parameter string INIT_FILE   = "load.hex",
  parameter int    START_DELAY = 100,
  parameter bit    RUN_BANK    = 1'b0,
  parameter logic [EXA_W-1:0] RD_BASE = '0,
  parameter int    RD_COUNT    = 16,
  // load table image; entry 0 in the LSBs
  parameter logic [LOAD_COUNT*(1+ROMULTIC_W+EXA_W+DATA_W)-1:0] LOAD_IMAGE = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic                  RUN,
  output logic                  BANK_SEL,
  output logic                  RE_FROM_EXTERNAL,
  output logic                  WE_FROM_EXTERNAL,
  output logic [ROMULTIC_W-1:0] ROMULTIC_BITS_FROM_EXTERNAL,
  output logic [EXA_W-1:0]      GLB_ADR_FROM_EXTERNAL,
  output logic [DATA_W-1:0]     DATA_FROM_EXTERNAL,
  input  logic [DATA_W-1:0]     DATA_TO_EXTERNAL,
  input  logic                  DONE
);

  localparam int WORD_W = 1 + ROMULTIC_W + EXA_W + DATA_W;
  localparam int IDX_W  = (LOAD_COUNT > 1) ? $clog2(LOAD_COUNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_RUN, S_DRAIN, S_READ, S_FINISH
  } state_t;

  logic [WORD_W-1:0] rom [LOAD_COUNT];

  generate
    for (genvar g = 0; g < LOAD_COUNT; g++) begin : g_w
      assign rom[g] = LOAD_IMAGE[g*WORD_W +: WORD_W];
    end
  endgenerate

  state_t                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    start_load;
  logic [IDX_W-1:0]        idx;
  logic [WORD_W-1:0]       entry;
  logic                    run_d, we_d, re_d, bank_d;
  logic [ROMULTIC_W-1:0]   rom_d;
  logic [EXA_W-1:0]        adr_d;
  logic [DATA_W-1:0]       data_d;
  logic                    rd_pending;
  logic [DATA_W-1:0]       rd_last;

  // outputs are registered from the next-state decode, so they line up with the state register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    bank_d  = 1'b0;
    rom_d   = '0;
    adr_d   = '0;
    data_d  = '0;
    start_load = ((state_q == S_IDLE) && (START_DELAY == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == 32'(START_DELAY - 1)));
    idx   = start_load ? '0 : IDX_W'(cnt_q + 32'd1);
    entry = rom[idx];
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: cnt_d = cnt_q + 32'd1;
      S_LOAD: begin
        if (cnt_q == 32'(LOAD_COUNT - 1)) begin
          state_d = S_RUN;
          run_d   = 1'b1;
          bank_d  = RUN_BANK;
        end else begin
          cnt_d = cnt_q + 32'd1;
          we_d  = 1'b1;
          {bank_d, rom_d, adr_d, data_d} = entry;
        end
      end
      S_RUN: begin
        bank_d = RUN_BANK;
        if (DONE) state_d = S_DRAIN;
        else      run_d   = 1'b1;
      end
      S_DRAIN: begin
        state_d = S_READ;
        bank_d  = RUN_BANK;
        cnt_d   = '0;
        re_d    = 1'b1;
        adr_d   = RD_BASE;
      end
      S_READ: begin
        bank_d = RUN_BANK;
        if (cnt_q == 32'(RD_COUNT - 1)) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 32'd1;
          re_d  = 1'b1;
          adr_d = RD_BASE + cnt_q[EXA_W-1:0] + EXA_W'(1);
        end
      end
      S_FINISH: bank_d = RUN_BANK;
      default:  state_d = S_IDLE;
    endcase
    if (start_load) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      we_d    = 1'b1;
      {bank_d, rom_d, adr_d, data_d} = entry;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q                     <= S_IDLE;
      cnt_q                       <= '0;
      RUN                         <= 1'b0;
      BANK_SEL                    <= 1'b0;
      RE_FROM_EXTERNAL            <= 1'b0;
      WE_FROM_EXTERNAL            <= 1'b0;
      ROMULTIC_BITS_FROM_EXTERNAL <= '0;
      GLB_ADR_FROM_EXTERNAL       <= '0;
      DATA_FROM_EXTERNAL          <= '0;
      rd_pending                  <= 1'b0;
      rd_last                     <= '0;
    end else begin
      state_q                     <= state_d;
      cnt_q                       <= cnt_d;
      RUN                         <= run_d;
      BANK_SEL                    <= bank_d;
      RE_FROM_EXTERNAL            <= re_d;
      WE_FROM_EXTERNAL            <= we_d;
      ROMULTIC_BITS_FROM_EXTERNAL <= rom_d;
      GLB_ADR_FROM_EXTERNAL       <= adr_d;
      DATA_FROM_EXTERNAL          <= data_d;
      // array answers one cycle after RE; capture that word and keep the last one
      rd_pending                  <= RE_FROM_EXTERNAL;
      if (rd_pending) rd_last <= DATA_TO_EXTERNAL;
    end
  end

endmodule

// File: tb/tb_cma_host_ctrl.sv
// tb/tb_cma_host_ctrl.sv - directed self-checking bench for cma_host_ctrl
module tb_cma_host_ctrl;

  localparam int SD = 5;
  localparam logic [47:0] E0 = {1'b1, 8'h01, 15'h0010, 24'h000AAA};
  localparam logic [47:0] E1 = {1'b0, 8'h0F, 15'h0011, 24'h555555};
  localparam logic [47:0] E2 = {1'b1, 8'hF0, 15'h0012, 24'h123456};
  localparam logic [47:0] E3 = {1'b0, 8'hFF, 15'h0013, 24'hFFFFFF};
  localparam logic [191:0] IMG = {E3, E2, E1, E0};

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DONE = 1'b0;
  logic        a_run, a_bank, a_re, a_we, b_run, b_bank, b_re, b_we;
  logic [7:0]  a_rom, b_rom;
  logic [14:0] a_adr, b_adr;
  logic [23:0] a_data, b_data;
  logic [23:0] a_dto = '0;
  logic [23:0] b_dto = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] ent [4];
  logic [14:0] wrap_adr [4];

  always #5 CLK = ~CLK;

  // array model: read data equals the address, returned one cycle later
  always @(posedge CLK) begin
    a_dto <= a_re ? {9'b0, a_adr} : 24'h0;
    b_dto <= b_re ? {9'b0, b_adr} : 24'h0;
  end

  cma_host_ctrl #(
    .LOAD_COUNT(4), .INIT_FILE(""), .START_DELAY(SD), .RUN_BANK(1'b1),
    .RD_BASE(15'd31), .RD_COUNT(20), .LOAD_IMAGE(IMG)
  ) dut_a (
    .CLK(CLK), .RST_N(RST_N), .RUN(a_run), .BANK_SEL(a_bank),
    .RE_FROM_EXTERNAL(a_re), .WE_FROM_EXTERNAL(a_we),
    .ROMULTIC_BITS_FROM_EXTERNAL(a_rom), .GLB_ADR_FROM_EXTERNAL(a_adr),
    .DATA_FROM_EXTERNAL(a_data), .DATA_TO_EXTERNAL(a_dto), .DONE(DONE)
  );

  cma_host_ctrl #(
    .LOAD_COUNT(4), .INIT_FILE(""), .START_DELAY(SD), .RUN_BANK(1'b0),
    .RD_BASE(15'h7FFE), .RD_COUNT(4), .LOAD_IMAGE(IMG)
  ) dut_b (
    .CLK(CLK), .RST_N(RST_N), .RUN(b_run), .BANK_SEL(b_bank),
    .RE_FROM_EXTERNAL(b_re), .WE_FROM_EXTERNAL(b_we),
    .ROMULTIC_BITS_FROM_EXTERNAL(b_rom), .GLB_ADR_FROM_EXTERNAL(b_adr),
    .DATA_FROM_EXTERNAL(b_data), .DATA_TO_EXTERNAL(b_dto), .DONE(DONE)
  );

  function automatic logic [63:0] mk(input logic run, input logic we, input logic re,
                                     input logic bank, input logic [7:0] rom,
                                     input logic [14:0] adr, input logic [23:0] data);
    return {13'b0, run, we, re, bank, rom, adr, data};
  endfunction

  logic [63:0] bus_a, bus_b;
  assign bus_a = mk(a_run, a_we, a_re, a_bank, a_rom, a_adr, a_data);
  assign bus_b = mk(b_run, b_we, b_re, b_bank, b_rom, b_adr, b_data);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // from reset release: every output 0 until WE appears START_DELAY+1 cycles later
  task automatic startup(input string tag);
    int cyc = 0;
    int nz = 0;
    while (!a_we && cyc < 200) begin
      if (bus_a != 64'd0 || bus_b != 64'd0) nz++;
      @(negedge CLK);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(SD + 1));
    check({tag, "_quiet"}, 64'(nz), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int run_cnt;
    ent[0] = E0; ent[1] = E1; ent[2] = E2; ent[3] = E3;
    wrap_adr[0] = 15'h7FFE; wrap_adr[1] = 15'h7FFF;
    wrap_adr[2] = 15'h0000; wrap_adr[3] = 15'h0001;

    RST_N = 1'b0;
    DONE  = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_a", bus_a, 64'd0);
    check("reset_b", bus_b, 64'd0);
    RST_N = 1'b1;
    startup("start");

    // DONE held high during most of the load must be ignored
    for (int k = 0; k < 4; k++) begin
      DONE = (k < 3);
      check($sformatf("load%0d", k), bus_a, {13'b0, 3'b010, ent[k]});
      @(negedge CLK);
    end
    check("run_rise_a", bus_a, mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h0, 15'h0, 24'h0));
    check("run_rise_b", bus_b, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 15'h0, 24'h0));

    run_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_run) run_cnt++;
      @(negedge CLK);
    end
    DONE = 1'b1;
    if (a_run) run_cnt++;
    @(negedge CLK);
    DONE = 1'b0;
    check("run_len", 64'(run_cnt), 64'd51);
    check("drain_a", bus_a, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 15'h0, 24'h0));
    @(negedge CLK);

    for (int k = 0; k < 20; k++) begin
      check($sformatf("read_a%0d", k), bus_a,
            mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h0, 15'(31 + k), 24'h0));
      if (k < 4)
        check($sformatf("wrap_b%0d", k), bus_b,
              mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h0, wrap_adr[k], 24'h0));
      else if (k == 4)
        check("finish_b", bus_b, 64'd0);
      @(negedge CLK);
    end
    check("finish_a", bus_a, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 15'h0, 24'h0));
    @(negedge CLK);
    check("last_a", 64'(dut_a.rd_last), 64'd50);
    check("last_b", 64'(dut_b.rd_last), 64'd1);

    // DONE glitches after the run must not wake anything up
    for (int g = 0; g < 3; g++) begin
      DONE = 1'b1;
      @(negedge CLK);
      DONE = 1'b0;
      check($sformatf("glitch%0d", g), bus_a, mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 15'h0, 24'h0));
    end
    check("last_hold", 64'(dut_a.rd_last), 64'd50);

    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    startup("seq2");
    repeat (4) @(negedge CLK);
    check("rerun", 64'(a_run), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check("async_run", 64'(a_run), 64'd0);
    check("async_bus", bus_a, 64'd0);
    check("async_last", 64'(dut_a.rd_last), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    startup("seq3");
    check("seq3_load0", bus_a, {13'b0, 3'b010, ent[0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
